hwemu_trace_capture: RTL and testbench

Passive capture stage for hardware-emulation tracing. It taps one valid/ready/data channel without driving it, timestamps every completed handshake against a free-running cycle counter, and buffers the records in an internal FIFO. Records drain through a valid/ready output stream to the trace writer. It sits directly downstream of the valid/ready/data trace tap and upstream of the trace sink.

---
 rtl/hwemu_trace_pkg.sv | 21 ++
 rtl/hwemu_trace_fifo.sv | 48 ++++
 rtl/hwemu_trace_capture.sv | 126 ++++++++++++
 tb/tb_hwemu_trace_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwemu_trace_pkg.sv
// Shared types and sizing for the hwemu trace capture block.
// HWEMU_TRACE_STALL_CNT_EN adds a 16-bit stall field to each record.
package hwemu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } trace_state_e;

    localparam int STALLW = 16;

    function automatic int rec_w(input int dataw, input int tsw);
`ifdef HWEMU_TRACE_STALL_CNT_EN
        return tsw + STALLW + dataw;
`else
        return tsw + dataw;
`endif
    endfunction

endpackage

// File: rtl/hwemu_trace_fifo.sv
// Synchronous record FIFO, registered storage and occupancy.
// A push into a full FIFO is accepted only alongside a pop.
module hwemu_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Head is forced to zero while empty so the idle output is clean.
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/hwemu_trace_capture.sv
// Passive valid/ready tap: timestamps handshakes into a trace FIFO.
// HWEMU_TRACE_STALL_CNT_EN adds a per-record stall cycle count.
module hwemu_trace_capture
    import hwemu_trace_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int DEPTH = 16,
    parameter int TSW   = 64,
    localparam int REC_W = rec_w(DATAW, TSW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trace_en,
    input  logic             tap_valid,
    input  logic             tap_ready,
    input  logic [DATAW-1:0] tap_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_data,
    output logic             overflow,
    output logic [31:0]      drop_cnt,
    output logic             busy,
    output logic             done
);
    trace_state_e     state_q;
    logic [TSW-1:0]   clkcnt_q;
    logic             overflow_q;
    logic [31:0]      drop_q;
    logic             busy_q;
    logic             done_q;
    logic             beat;
    logic             cap;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [REC_W-1:0] rec;

    assign beat = tap_valid && tap_ready;
    assign cap  = beat && (state_q == ST_RUN);
    assign pop  = out_valid && out_ready;
    assign drop = cap && full && !pop;

    assign out_valid = !empty;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef HWEMU_TRACE_STALL_CNT_EN
    logic [STALLW-1:0] stall_q;

    assign rec = {clkcnt_q, stall_q, tap_data};

    // Stall run restarts at capture start and on every beat seen in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (state_q == ST_IDLE && trace_en) begin
            stall_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (beat) begin
                stall_q <= '0;
            end else if (tap_valid && stall_q != '1) begin
                stall_q <= stall_q + STALLW'(1);
            end
        end
    end
`else
    assign rec = {clkcnt_q, tap_data};
`endif

    hwemu_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cap),
        .wdata_i (rec),
        .pop_i   (pop),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            clkcnt_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            clkcnt_q <= clkcnt_q + TSW'(1);
            done_q   <= 1'b0;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + 32'd1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (trace_en) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                        drop_q     <= '0;
                    end
                end
                ST_RUN: begin
                    if (!trace_en) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (empty) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hwemu_trace_capture.sv
// Randomised and directed bench for hwemu_trace_capture with a
// queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_hwemu_trace_capture;
    import hwemu_trace_pkg::*;

    localparam int DATAW = 8;
    localparam int DEPTH = 16;
    localparam int TSW   = 64;
    localparam int REC_W = rec_w(DATAW, TSW);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             trace_en = 1'b0;
    logic             tap_valid = 1'b0;
    logic             tap_ready = 1'b0;
    logic [DATAW-1:0] tap_data = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [REC_W-1:0] out_data;
    logic             overflow;
    logic [31:0]      drop_cnt;
    logic             busy;
    logic             done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hwemu_trace_capture #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .TSW   (TSW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trace_en  (trace_en),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_data  (tap_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .busy      (busy),
        .done      (done)
    );

    // Reference model state
    logic [REC_W-1:0] mq[$];
    logic [TSW-1:0]   m_cnt = '0;
    int               m_mode = 0;
    bit               m_ovf = 0;
    longint           m_drop = 0;
    bit               m_done = 0;
    int               m_stall = 0;
    bit               chk_en = 0;

    function automatic logic [REC_W-1:0] mk(
        input logic [TSW-1:0] ts, input int st, input logic [DATAW-1:0] d);
`ifdef HWEMU_TRACE_STALL_CNT_EN
        return {ts, 16'(st), d};
`else
        return {ts, d} | REC_W'(st & 0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int  n0;
        bit  pop;
        bit  beat;
        if (!rst) begin
            mq.delete();
            m_cnt   = '0;
            m_mode  = 0;
            m_ovf   = 0;
            m_drop  = 0;
            m_done  = 0;
            m_stall = 0;
            chk_en  = 1;
        end else begin
            n0     = mq.size();
            pop    = (n0 > 0) && out_ready;
            beat   = tap_valid && tap_ready;
            m_done = 0;
            if (pop) void'(mq.pop_front());
            if (m_mode == 1) begin
                if (beat) begin
                    if (n0 < DEPTH || pop) begin
                        mq.push_back(mk(m_cnt, m_stall, tap_data));
                    end else begin
                        m_ovf = 1;
                        if (m_drop < 64'hFFFF_FFFF) m_drop++;
                    end
                    m_stall = 0;
                end else if (tap_valid) begin
                    m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
                end
            end
            case (m_mode)
                0: if (trace_en) begin
                    m_mode = 1; m_ovf = 0; m_drop = 0; m_stall = 0;
                end
                1: if (!trace_en) m_mode = 2;
                default: if (n0 == 0) begin m_mode = 0; m_done = 1; end
            endcase
            m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) chk("out_data", out_data, mq[0]);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop[31:0]);
            chk("busy", busy, m_mode != 0);
            chk("done", done, m_done);
        end
    end

    task automatic wait_cnt(input logic [TSW-1:0] c);
        for (int i = 0; i < 200 && m_cnt != c; i++) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int n;
        logic [REC_W-1:0] lit;

        @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b1;
        trace_en = 1'b1;

        // Single beat stamped at clkcnt 10
        wait_cnt(10);
        chk("single_pre_valid", out_valid, 0);
        tap_valid = 1; tap_ready = 1; tap_data = 8'hA5;
        @(negedge clk);
        tap_valid = 0; tap_ready = 0;
`ifdef HWEMU_TRACE_STALL_CNT_EN
        lit = {64'd10, 16'd0, 8'hA5};
`else
        lit = {64'd10, 8'hA5};
`endif
        chk("single_valid", out_valid, 1);
        chk("single_rec", out_data, lit);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;

        // 20 beats into a 16-deep FIFO with the sink stalled
        for (int i = 0; i < 20; i++) begin
            tap_valid = 1; tap_ready = 1; tap_data = DATAW'($urandom);
            @(negedge clk);
        end
        tap_valid = 0; tap_ready = 0;
        @(negedge clk);
        chk("ovf_drop_cnt", drop_cnt, 4);
        chk("ovf_flag", overflow, 1);

        // Full FIFO, push and pop together: no loss
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tap_valid = 1; tap_ready = 1; tap_data = DATAW'($urandom);
            @(negedge clk);
        end
        tap_valid = 0; tap_ready = 0;
        chk("full_pp_drop_cnt", drop_cnt, 4);
        n = 0;
        for (int i = 0; i < 40 && out_valid; i++) begin
            n++;
            @(negedge clk);
        end
        chk("full_pp_occupancy", n, 16);

        // Stop with 3 records queued
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tap_valid = 1; tap_ready = 1; tap_data = DATAW'(8'h10 + i);
            @(negedge clk);
        end
        trace_en = 0; tap_valid = 0; tap_ready = 0; out_ready = 1;
        @(negedge clk);
        tap_valid = 1; tap_ready = 1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n++;
            @(negedge clk);
        end
        tap_valid = 0; tap_ready = 0;
        chk("stop_done_pulses", n, 1);
        chk("stop_busy", busy, 0);
        chk("stop_no_capture", out_valid, 0);

        // Stall counting
        out_ready = 0;
        trace_en = 1;
        @(negedge clk);
        tap_valid = 1; tap_ready = 0;
        repeat (5) @(negedge clk);
        tap_ready = 1; tap_data = 8'h5A;
        @(negedge clk);
        tap_data = 8'h5B;
        @(negedge clk);
        tap_valid = 0; tap_ready = 0;
`ifdef HWEMU_TRACE_STALL_CNT_EN
        chk("stall_first", out_data[DATAW +: 16], 5);
`endif
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
`ifdef HWEMU_TRACE_STALL_CNT_EN
        chk("stall_second", out_data[DATAW +: 16], 0);
`endif
        chk("stall_second_data", out_data[DATAW-1:0], 8'h5B);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) trace_en = ~trace_en;
            tap_valid = $urandom_range(0, 99) < 70;
            tap_ready = $urandom_range(0, 99) < ((i % 600 < 300) ? 80 : 40);
            tap_data  = DATAW'($urandom);
            out_ready = $urandom_range(0, 99) < ((i % 400 < 200) ? 30 : 90);
            @(negedge clk);
        end

        // Reset while draining
        trace_en = 0; tap_valid = 0; tap_ready = 0; out_ready = 1;
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        trace_en = 1; out_ready = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tap_valid = 1; tap_ready = 1; tap_data = DATAW'($urandom);
            @(negedge clk);
        end
        trace_en = 0; tap_valid = 0; tap_ready = 0;
        repeat (2) @(negedge clk);
        chk("mid_drain_busy", busy, 1);
        rst = 0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst = 1;
        trace_en = 1;
        wait_cnt(3);
        tap_valid = 1; tap_ready = 1; tap_data = 8'h3C;
        @(negedge clk);
        tap_valid = 0; tap_ready = 0;
`ifdef HWEMU_TRACE_STALL_CNT_EN
        lit = {64'd3, 16'd0, 8'h3C};
`else
        lit = {64'd3, 8'h3C};
`endif
        chk("post_rst_ts", out_data, lit);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
